// File: rtl/equiv_check_harness_if.sv
// Handshake/bus bundle between the equivalence harness and the stimulus/DUT side.
// Parameters must match those of the equiv_check_harness instance it connects to.
interface equiv_check_harness_if #(
  parameter int IN_W  = 53,
  parameter int OUT_W = 258,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [OUT_W-1:0] cmp_mask;
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] gold_y;
  logic [OUT_W-1:0] dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [15:0]      first_idx;
  logic [OUT_W-1:0] first_diff;

  modport master (
    output start, abort, cmp_mask, gold_y, dut_y,
    input  stim, busy, done, pass, mismatch_cnt, first_idx, first_diff
  );

  modport slave (
    input  start, abort, cmp_mask, gold_y, dut_y,
    output stim, busy, done, pass, mismatch_cnt, first_idx, first_diff
  );
endinterface

// File: rtl/equiv_check_harness.sv
// LFSR-driven lock-step equivalence harness: issues NUM_VEC vectors, compares golden vs
// netlist outputs LAT+1 cycles after issue under a mask, reports count/first failure.
module equiv_check_harness #(
  parameter int          IN_W    = 53,
  parameter int          OUT_W   = 258,
  parameter int          NUM_VEC = 20,
  parameter int          LAT     = 0,
  parameter logic [63:0] SEED    = 64'h19c47bbf0773ab79,
  parameter int          CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  equiv_check_harness_if.slave bus
);

  localparam logic [63:0] SEED_EFF = (SEED == 64'd0) ? 64'd1 : SEED;
  localparam logic [63:0] POLY     = 64'hD800_0000_0000_0000;
  localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [63:0]      lfsr;
  logic [15:0]      vec_idx;
  logic             pipe_vld [0:LAT];
  logic [15:0]      pipe_idx [0:LAT];
  logic [OUT_W-1:0] diff;
  logic             pipe_empty;

  assign diff = (bus.gold_y ^ bus.dut_y) & bus.cmp_mask;

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i <= LAT; i++) begin
      if (pipe_vld[i]) pipe_empty = 1'b0;
    end
  end

  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      lfsr             <= SEED_EFF;
      vec_idx          <= '0;
      bus.stim         <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.pass         <= 1'b0;
      bus.mismatch_cnt <= '0;
      bus.first_idx    <= '0;
      bus.first_diff   <= '0;
      for (int i = 0; i <= LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_idx[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          // abort arriving with start suppresses the new run
          if (bus.start && !bus.abort) begin
            state            <= RUN;
            lfsr             <= SEED_EFF;
            vec_idx          <= '0;
            bus.busy         <= 1'b1;
            bus.done         <= 1'b0;
            bus.pass         <= 1'b0;
            bus.mismatch_cnt <= '0;
            bus.first_idx    <= '0;
            bus.first_diff   <= '0;
            for (int i = 0; i <= LAT; i++) pipe_vld[i] <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            for (int i = 0; i <= LAT; i++) pipe_vld[i] <= 1'b0;
          end else begin
            pipe_vld[0] <= (state == RUN);
            pipe_idx[0] <= vec_idx;
            for (int i = 1; i <= LAT; i++) begin
              pipe_vld[i] <= pipe_vld[i-1];
              pipe_idx[i] <= pipe_idx[i-1];
            end

            // count is saturating, so zero reliably marks "no failure seen yet"
            if (pipe_vld[LAT] && (diff != '0)) begin
              if (bus.mismatch_cnt != '1) bus.mismatch_cnt <= bus.mismatch_cnt + CNT_W'(1);
              if (bus.mismatch_cnt == '0) begin
                bus.first_idx  <= pipe_idx[LAT];
                bus.first_diff <= diff;
              end
            end

            if (state == RUN) begin
              bus.stim <= lfsr[IN_W-1:0];
              lfsr     <= lfsr_step(lfsr);
              vec_idx  <= vec_idx + 16'd1;
              if (vec_idx == LAST_IDX) state <= DRAIN;
            end else if (pipe_empty) begin
              state    <= DONE;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              bus.pass <= (bus.mismatch_cnt == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_equiv_check_harness.sv
// Directed bench: default instance (LAT=0, CNT_W=16) and a LAT=2, CNT_W=3 instance.
// Edge numbering restarts at 0 on the edge where start is sampled.
module tb_equiv_check_harness;
  localparam int IN_W  = 53;
  localparam int OUT_W = 258;

  localparam logic [52:0] V0 = 53'h047bbf0773ab79;
  localparam logic [52:0] V1 = 53'h023ddf83b9d5bc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;

  logic [OUT_W-1:0] a_inj = '0;
  logic [OUT_W-1:0] b_inj = '0;

  always #5 clk = ~clk;

  equiv_check_harness_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(16)) ifa ();
  equiv_check_harness_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(3))  ifb ();

  assign ifa.gold_y = OUT_W'({ifa.stim, ifa.stim, ifa.stim, ifa.stim, ifa.stim});
  assign ifa.dut_y  = ifa.gold_y ^ a_inj;
  assign ifb.gold_y = OUT_W'({ifb.stim, ifb.stim, ifb.stim, ifb.stim, ifb.stim});
  assign ifb.dut_y  = ifb.gold_y ^ b_inj;

  equiv_check_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(20), .LAT(0), .CNT_W(16))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  equiv_check_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(20), .LAT(2), .CNT_W(3))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_a();
    ifa.start = 1'b1;
    tick();
    edge_n = 0;
    ifa.start = 1'b0;
  endtask

  task automatic start_b();
    ifb.start = 1'b1;
    tick();
    edge_n = 0;
    ifb.start = 1'b0;
  endtask

  initial begin
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.cmp_mask = '1;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.cmp_mask = '1;
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy",  ifa.busy, 0);
    chk("rst_done",  ifa.done, 0);
    chk("rst_pass",  ifa.pass, 0);
    chk("rst_cnt",   ifa.mismatch_cnt, 0);
    chk("rst_fidx",  ifa.first_idx, 0);
    chk("rst_fdiff", ifa.first_diff, 0);
    chk("rst_stim",  ifa.stim, 0);
    chk("rst_b_cnt", ifb.mismatch_cnt, 0);
    rst = 1'b0;
    tick();

    // clean run, default instance
    start_a();
    chk("a_busy_e0", ifa.busy, 1);
    tick();
    chk("a_stim_v0", ifa.stim, V0);
    tick();
    chk("a_stim_v1", ifa.stim, V1);
    while (edge_n < 21) begin
      tick();
      chk("a_busy_run", ifa.busy, 1);
      chk("a_done_run", ifa.done, 0);
    end
    tick();
    chk("a_done_e22", ifa.done, 1);
    chk("a_busy_e22", ifa.busy, 0);
    chk("a_pass",     ifa.pass, 1);
    chk("a_cnt",      ifa.mismatch_cnt, 0);

    // single failure on vector 7, LAT=2: compared at edge 11
    start_b();
    while (edge_n < 23) begin
      tick();
      b_inj = (edge_n == 10) ? OUT_W'(1) : '0;
      if (edge_n == 11) chk("b_cnt_e11", ifb.mismatch_cnt, 1);
    end
    chk("b_done_e23", ifb.done, 0);
    tick();
    chk("b_done_e24", ifb.done, 1);
    chk("b_pass",     ifb.pass, 0);
    chk("b_cnt",      ifb.mismatch_cnt, 1);
    chk("b_fidx",     ifb.first_idx, 7);
    chk("b_fdiff",    ifb.first_diff, 1);

    // persistent bit-5 difference, masked out then compared
    a_inj = OUT_W'(32);
    ifa.cmp_mask = ~OUT_W'(32);
    start_a();
    while (edge_n < 22) tick();
    chk("mask_done", ifa.done, 1);
    chk("mask_pass", ifa.pass, 1);
    chk("mask_cnt",  ifa.mismatch_cnt, 0);
    ifa.cmp_mask = '1;
    start_a();
    while (edge_n < 22) tick();
    chk("bit5_done",  ifa.done, 1);
    chk("bit5_pass",  ifa.pass, 0);
    chk("bit5_cnt",   ifa.mismatch_cnt, 20);
    chk("bit5_fidx",  ifa.first_idx, 0);
    chk("bit5_fdiff", ifa.first_diff, 32);
    a_inj = '0;

    // saturation with CNT_W=3
    b_inj = OUT_W'(1);
    start_b();
    while (edge_n < 24) tick();
    chk("sat_done", ifb.done, 1);
    chk("sat_cnt",  ifb.mismatch_cnt, 7);
    chk("sat_fidx", ifb.first_idx, 0);
    b_inj = '0;

    // abort mid-run, then restart reproduces vector 0
    start_a();
    while (edge_n < 5) tick();
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    chk("abort_busy", ifa.busy, 0);
    chk("abort_done", ifa.done, 0);
    tick();
    chk("abort_stay_busy", ifa.busy, 0);
    ifa.start = 1'b1; ifa.abort = 1'b1;
    tick();
    ifa.start = 1'b0; ifa.abort = 1'b0;
    chk("abort_wins_busy", ifa.busy, 0);
    start_a();
    tick();
    chk("restart_v0", ifa.stim, V0);
    while (edge_n < 22) tick();
    chk("restart_done", ifa.done, 1);

    // synchronous reset mid-run
    start_a();
    while (edge_n < 4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", ifa.busy, 0);
    chk("mrst_done", ifa.done, 0);
    chk("mrst_stim", ifa.stim, 0);
    chk("mrst_cnt",  ifa.mismatch_cnt, 0);
    tick();
    chk("mrst_idle", ifa.busy, 0);

    // start during RUN is ignored
    start_a();
    while (edge_n < 5) tick();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    while (edge_n < 21) tick();
    chk("ign_done_e21", ifa.done, 0);
    tick();
    chk("ign_done_e22", ifa.done, 1);
    chk("ign_pass",     ifa.pass, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
